// File: rtl/wb_master_bridge_if.sv
// Command/response channel and Wishbone classic master bus for wb_master_bridge.
// The master modport is the bridge's view. The slave modport is the loader/bus side.
interface wb_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_adr;
  logic [DATA_WIDTH-1:0] cmd_dat;
  logic [SEL_WIDTH-1:0]  cmd_sel;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_dat;
  logic                  rsp_err;
  logic                  wbm_cyc_o;
  logic                  wbm_stb_o;
  logic                  wbm_we_o;
  logic [SEL_WIDTH-1:0]  wbm_sel_o;
  logic [ADDR_WIDTH-1:0] wbm_adr_o;
  logic [DATA_WIDTH-1:0] wbm_dat_o;
  logic                  wbm_ack_i;
  logic [DATA_WIDTH-1:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wbm_ack_i, wbm_dat_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer initiator: one bus cycle per command, with a bus timeout.
// The interface parameters must match this module's parameters.
module wb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255,
  parameter int TO_WIDTH   = $clog2(TIMEOUT + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t                state, state_nx;
  logic                  accept, ack_done, to_done;
  logic [TO_WIDTH-1:0]   to_cnt;
  logic                  cyc_q, stb_q, we_q, rsp_valid_q, rsp_err_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q, rsp_dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)                 state_nx = BUS;
      BUS:     if (ack_done || to_done)    state_nx = RESP;
      RESP:    if (bus.rsp_ready)          state_nx = IDLE;
      default:                             state_nx = IDLE;
    endcase
  end

  // cmd_ready is gated by rst_n so it reads 0 while reset is held.
  // An ack arriving in the timeout cycle wins over the timeout.
  always_comb begin
    bus.cmd_ready = (state == IDLE) && rst_n;
    accept        = bus.cmd_ready && bus.cmd_valid;
    ack_done      = (state == BUS) && bus.wbm_ack_i;
    to_done       = (state == BUS) && !bus.wbm_ack_i && (TIMEOUT != 0) && (to_cnt == TO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      to_cnt      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else if (accept) begin
      cyc_q  <= 1'b1;
      stb_q  <= 1'b1;
      we_q   <= bus.cmd_we;
      sel_q  <= bus.cmd_sel;
      adr_q  <= bus.cmd_adr;
      dat_q  <= bus.cmd_dat;
      to_cnt <= '0;
    end else if (state == BUS) begin
      if (ack_done || to_done) begin
        cyc_q       <= 1'b0;
        stb_q       <= 1'b0;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= to_done;
        rsp_dat_q   <= (ack_done && !we_q) ? bus.wbm_dat_i : '0;
      end else if (to_cnt != '1) begin
        to_cnt <= to_cnt + TO_WIDTH'(1);
      end
    end else if (state == RESP && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Bus qualifiers keep their last value after the cycle; slaves qualify them with stb.
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = stb_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_dat   = rsp_dat_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge with TIMEOUT=8 and a scripted Wishbone slave.
module tb_wb_master_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  wb_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4)) bus();

  wb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and act as slave: ack on stb cycle ack_cyc (0 = never ack).
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int ack_cyc, input logic [31:0] rdat,
                      output int stb_n, output logic stable);
    logic acc;
    acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    bus.cmd_sel   = sel;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.wbm_stb_o) begin acc = 1'b1; break; end
    end
    bus.cmd_valid = 1'b0;
    chk("accept", {31'b0, acc}, 32'd1);
    stb_n  = 0;
    stable = 1'b1;
    for (int i = 0; i < 50 && bus.wbm_stb_o; i++) begin
      stb_n++;
      if (!bus.wbm_cyc_o || bus.wbm_we_o !== we || bus.wbm_adr_o !== adr ||
          bus.wbm_sel_o !== sel || bus.wbm_dat_o !== dat) stable = 1'b0;
      if (stb_n == ack_cyc) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = rdat;
      end
      tick();
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = 32'hBAD0_BAD0;
    end
  endtask

  initial begin
    int   sn;
    logic st;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    bus.cmd_sel   = '0;
    bus.rsp_ready = 1'b1;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'hBAD0_BAD0;

    tick();
    tick();
    chk("rst_ready", {31'b0, bus.cmd_ready}, 32'd0);
    chk("rst_outs", {29'b0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", {31'b0, bus.cmd_ready}, 32'd1);

    // Write, acked on the 2nd stb cycle
    xfer(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'h0, sn, st);
    chk("wr_stb_cycles", sn, 2);
    chk("wr_stable", {31'b0, st}, 32'd1);
    chk("wr_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("wr_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    chk("wr_rsp_dat", bus.rsp_dat, 32'h0);
    chk("wr_cyc_low", {31'b0, bus.wbm_cyc_o}, 32'd0);

    // Read, zero-wait ack
    xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 32'h0000_07FF, sn, st);
    chk("rd_stb_cycles", sn, 1);
    chk("rd_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("rd_rsp_dat", bus.rsp_dat, 32'h0000_07FF);
    chk("rd_rsp_err", {31'b0, bus.rsp_err}, 32'd0);

    // Timeout, slave never acks
    xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, 0, 32'h0, sn, st);
    chk("to_stb_cycles", sn, 8);
    chk("to_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
    chk("to_rsp_err", {31'b0, bus.rsp_err}, 32'd1);
    chk("to_rsp_dat", bus.rsp_dat, 32'h0);
    xfer(1'b0, 32'h3000_0024, 32'h0, 4'h3, 3, 32'h1234_5678, sn, st);
    chk("after_to_stb", sn, 3);
    chk("after_to_dat", bus.rsp_dat, 32'h1234_5678);
    chk("after_to_err", {31'b0, bus.rsp_err}, 32'd0);

    // Ack in the same cycle as timeout expiry
    xfer(1'b0, 32'h3000_0028, 32'h0, 4'hF, 8, 32'hCAFE_0008, sn, st);
    chk("col_stb_cycles", sn, 8);
    chk("col_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    chk("col_rsp_dat", bus.rsp_dat, 32'hCAFE_0008);

    // Stray ack while idle
    tick();
    tick();
    bus.wbm_ack_i = 1'b1;
    bus.wbm_dat_i = 32'h5555_5555;
    tick();
    bus.wbm_ack_i = 1'b0;
    chk("stray_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    tick();
    chk("stray_rsp2", {30'b0, bus.rsp_valid, bus.wbm_cyc_o}, 32'd0);

    // Backpressure with a second command queued
    bus.rsp_ready = 1'b0;
    xfer(1'b0, 32'h3000_0030, 32'h0, 4'hF, 2, 32'hA5A5_0001, sn, st);
    chk("bp_rsp_valid0", {31'b0, bus.rsp_valid}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_adr   = 32'h3000_0040;
    bus.cmd_dat   = 32'h0BAD_F00D;
    bus.cmd_sel   = 4'hC;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("bp_dat", bus.rsp_dat, 32'hA5A5_0001);
      chk("bp_ready_low", {30'b0, bus.cmd_ready, bus.wbm_stb_o}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_hs_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("bp_hs_stb", {31'b0, bus.wbm_stb_o}, 32'd0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("bp_q_stb", {31'b0, bus.wbm_stb_o}, 32'd1);
    chk("bp_q_adr", bus.wbm_adr_o, 32'h3000_0040);
    bus.wbm_ack_i = 1'b1;
    tick();
    bus.wbm_ack_i = 1'b0;
    chk("bp_q_rsp", {30'b0, bus.rsp_valid, bus.rsp_err}, 32'd2);
    tick();

    // Reset mid-BUS
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_adr   = 32'h3000_0050;
    bus.cmd_dat   = 32'hFFFF_0000;
    bus.cmd_sel   = 4'h5;
    tick();
    bus.cmd_valid = 1'b0;
    chk("mid_stb_high", {31'b0, bus.wbm_stb_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_drop", {30'b0, bus.wbm_cyc_o, bus.wbm_stb_o}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_outs", {26'b0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o,
                          bus.rsp_valid, bus.rsp_err, |bus.wbm_sel_o}, 32'd0);
    chk("post_rst_bus", bus.wbm_adr_o | bus.wbm_dat_o | bus.rsp_dat, 32'h0);
    chk("post_rst_ready", {31'b0, bus.cmd_ready}, 32'd1);

    xfer(1'b0, 32'h3000_0060, 32'h0, 4'hF, 1, 32'h0000_0042, sn, st);
    chk("post_rst_rd", bus.rsp_dat, 32'h0000_0042);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
